// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-specifier width, hazard-controller
// state encodings and the per-action control bundle.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    LU  = 2'd1,
    BR  = 2'd2,
    XS  = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
  } hz_ctrl_t;

  // Control pattern driven for a given per-cycle action.
  function automatic hz_ctrl_t ctrl_of(input hz_state_t action);
    hz_ctrl_t c;
    case (action)
      BR:      c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
      XS, LU:  c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
      default: c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/flush controller: load-use stalls, taken-branch squashes and external
// freeze, with saturating stall/flush event counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W = pipe_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_rt_used,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             branch_taken,
  input  logic             ext_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t state_p0;
  hz_state_t nxt_p0;
  hz_ctrl_t  ctrl;
  logic      lu;
  logic      lu_ok;
  logic      stall_inc;
  logic      flush_inc;

  // A load in EX whose destination feeds the ID instruction; $zero never hazards.
  assign lu = idex_memread && (idex_rt != '0) &&
              ((idex_rt == ifid_rs) || (ifid_rt_used && (idex_rt == ifid_rt)));

  // After a bubble (LU) or squash (BR) the same pair must not stall again.
  assign lu_ok = lu && (state_p0 != LU) && (state_p0 != BR);

  always_comb begin
    nxt_p0 = RUN;
    if (branch_taken)   nxt_p0 = BR;
    else if (ext_stall) nxt_p0 = XS;
    else if (lu_ok)     nxt_p0 = LU;

    ctrl = ctrl_of(nxt_p0);
    if (!rst_n) begin
      ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_p0 <= RUN;
    else        state_p0 <= nxt_p0;
  end

  assign pc_write   = ctrl.pc_write;
  assign ifid_write = ctrl.ifid_write;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign state      = state_p0;

  assign stall_inc = (nxt_p0 == XS) || (nxt_p0 == LU);
  assign flush_inc = (nxt_p0 == BR);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with 4-bit counters so saturation is reachable.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] ifid_rs, ifid_rt, idex_rt;
  logic             ifid_rt_used, idex_memread, branch_taken, ext_stall;
  logic             pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_rt_used (ifid_rt_used),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .branch_taken (branch_taken),
    .ext_stall    (ext_stall),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combinational controls checked mid-cycle: {pc_write, ifid_write, ifid_flush, idex_flush}.
  task automatic chk_ctrl(input string tag, input logic [3:0] exp);
    @(negedge clk);
    chk(tag, {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, exp});
  endtask

  // Advance past the next rising edge and check registered state/counters.
  task automatic chk_regs(input string tag, input logic [1:0] st, input int sc, input int fc);
    @(posedge clk);
    #1;
    chk({tag, ".state"}, {30'd0, state}, {30'd0, st});
    chk({tag, ".stall"}, {28'd0, stall_cnt}, sc[31:0]);
    chk({tag, ".flush"}, {28'd0, flush_cnt}, fc[31:0]);
  endtask

  task automatic idle_inputs();
    ifid_rs = '0; ifid_rt = '0; ifid_rt_used = 1'b0;
    idex_memread = 1'b0; idex_rt = '0; branch_taken = 1'b0; ext_stall = 1'b0;
  endtask

  initial begin
    idle_inputs();
    // Reset held 2 cycles with a load-use condition present.
    rst_n = 1'b0; idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    #1;
    chk_ctrl("rst_c1", 4'b0011);
    @(posedge clk); #1;
    chk_ctrl("rst_c2", 4'b0011);
    @(posedge clk); #1;
    rst_n = 1'b1; idle_inputs();
    chk("rst.state", {30'd0, state}, 32'd0);
    chk("rst.stall", {28'd0, stall_cnt}, 32'd0);
    chk("rst.flush", {28'd0, flush_cnt}, 32'd0);

    // Load-use via rs: exactly one bubble, even with memread still high.
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    chk_ctrl("lu_rs", 4'b0001);
    chk_regs("lu_rs", 2'd1, 1, 0);
    chk_ctrl("lu_mask", 4'b1100);
    chk_regs("lu_mask", 2'd0, 1, 0);

    // No hazard: $zero destination, and rt match without rt use.
    idle_inputs(); idex_memread = 1'b1;
    chk_ctrl("nohz_zero", 4'b1100);
    chk_regs("nohz_zero", 2'd0, 1, 0);
    idex_rt = 5'd8; ifid_rs = 5'd3; ifid_rt = 5'd8;
    chk_ctrl("nohz_rtunused", 4'b1100);
    chk_regs("nohz_rtunused", 2'd0, 1, 0);
    ifid_rt_used = 1'b1;
    chk_ctrl("lu_rt", 4'b0001);
    chk_regs("lu_rt", 2'd1, 2, 0);
    idle_inputs();
    chk_regs("idle1", 2'd0, 2, 0);

    // Branch wins over a simultaneous load-use; lu then masked in BR.
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; branch_taken = 1'b1;
    chk_ctrl("br_lu", 4'b1111);
    chk_regs("br_lu", 2'd2, 2, 1);
    branch_taken = 1'b0;
    chk_ctrl("br_mask", 4'b1100);
    chk_regs("br_mask", 2'd0, 2, 1);

    // ext_stall for 3 cycles with lu pending, then the lu bubble.
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_ctrl("xs", 4'b0001);
      chk_regs("xs", 2'd3, 3 + i, 1);
    end
    ext_stall = 1'b0;
    chk_ctrl("xs_then_lu", 4'b0001);
    chk_regs("xs_then_lu", 2'd1, 6, 1);
    idle_inputs();
    chk_regs("idle2", 2'd0, 6, 1);

    // Saturation: 20 cycles of ext_stall from 6 must stop at 15.
    ext_stall = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sat.stall", {28'd0, stall_cnt}, 32'd15);
    chk("sat.state", {30'd0, state}, 32'd3);
    chk("sat.flush", {28'd0, flush_cnt}, 32'd1);
    chk_ctrl("sat_xs", 4'b0001);

    // Reset clears saturated counters.
    rst_n = 1'b0; idle_inputs();
    chk_ctrl("rst2", 4'b0011);
    chk_regs("rst2", 2'd0, 0, 0);
    rst_n = 1'b1;
    chk_ctrl("run_after_rst", 4'b1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
